clock_set_ctrl: RTL and testbench

Mode and time-set controller for the digital clock. Sits between the frequency-divider strobes and the seconds/minutes/hours counter chain: in RUN it forwards the 1 Hz strobe to the seconds counter; in the two SET modes it freezes seconds, issues increment pulses to the selected field (single press or auto-repeat while held), and drives blank signals for the selected display field.

---
 rtl/clock_ctrl_pkg.sv | 11 +
 rtl/clock_set_ctrl_rise_detect.sv | 12 +
 rtl/clock_set_ctrl.sv | 87 ++++++++
 tb/tb_clock_set_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: mode encoding shared by the set controller and the display mux.
package clock_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;
  function automatic mode_t next_mode(input mode_t m);
    return m == MODE_RUN ? MODE_SET_HOUR : m == MODE_SET_HOUR ? MODE_SET_MIN : MODE_RUN;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_rise_detect.sv
// rise_detect: one-cycle pulse on a rising level; prev resets high so a held button gives no edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic prev_d, prev_q;
  always_comb prev_d = rst ? 1'b1 : in;
  always_ff @(posedge clk) prev_q <= prev_d;
  assign rise = in & ~prev_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode FSM with press, auto-repeat increments and field blink.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int BLINK_TICKS  = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_sec,
  input  logic       tick_fast,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_en,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       clr_sec,
  output logic       blank_min,
  output logic       blank_hour,
  output logic [1:0] mode
);
  mode_t state_d, state_q;
  logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q, blink_cnt_d, blink_cnt_q, hold_term;
  logic rep_d, rep_q, phase_d, phase_q;
  logic sec_en_d, sec_en_q, inc_min_d, inc_min_q, inc_hour_d, inc_hour_q, clr_sec_d, clr_sec_q;
  logic blank_min_d, blank_min_q, blank_hour_d, blank_hour_q;
  logic mode_rise, inc_rise, move, hold_on, rep_hit, inc, blink_wrap, blink_clr;
  rise_detect u_mode_rise (.clk(clock_in), .rst(reset), .in(btn_mode), .rise(mode_rise));
  rise_detect u_inc_rise  (.clk(clock_in), .rst(reset), .in(btn_inc),  .rise(inc_rise));
  always_comb begin
    move         = mode_rise;
    state_d      = (move || !(state_q inside {MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN})) ? next_mode(state_q) : state_q;
    // a mode change takes priority over any pending increment
    hold_on      = (state_q == MODE_SET_HOUR || state_q == MODE_SET_MIN) & btn_inc & ~move;
    hold_term    = rep_q ? CNT_W'(REPEAT_TICKS - 1) : CNT_W'(HOLD_TICKS - 1);
    rep_hit      = hold_on & tick_fast & (hold_cnt_q == hold_term);
    inc          = hold_on & (inc_rise | rep_hit);
    hold_cnt_d   = !hold_on ? '0 : !tick_fast ? hold_cnt_q : rep_hit ? '0 : hold_cnt_q + CNT_W'(1);
    rep_d        = hold_on & (rep_q | rep_hit);
    blink_wrap   = tick_fast & (blink_cnt_q == CNT_W'(BLINK_TICKS - 1));
    blink_clr    = move | inc;
    blink_cnt_d  = blink_clr ? '0 : !tick_fast ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_q + CNT_W'(1);
    phase_d      = blink_clr ? 1'b0 : phase_q ^ blink_wrap;
    sec_en_d     = tick_sec & (state_q == MODE_RUN);
    inc_hour_d   = inc & (state_q == MODE_SET_HOUR);
    inc_min_d    = inc & (state_q == MODE_SET_MIN);
    clr_sec_d    = move & (state_q == MODE_SET_MIN);
    blank_hour_d = (state_d == MODE_SET_HOUR) & phase_d;
    blank_min_d  = (state_d == MODE_SET_MIN) & phase_d;
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= MODE_RUN;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      rep_q        <= 1'b0;
      phase_q      <= 1'b0;
      sec_en_q     <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_hour_q   <= 1'b0;
      clr_sec_q    <= 1'b0;
      blank_min_q  <= 1'b0;
      blank_hour_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      rep_q        <= rep_d;
      phase_q      <= phase_d;
      sec_en_q     <= sec_en_d;
      inc_min_q    <= inc_min_d;
      inc_hour_q   <= inc_hour_d;
      clr_sec_q    <= clr_sec_d;
      blank_min_q  <= blank_min_d;
      blank_hour_q <= blank_hour_d;
    end
  end
  assign sec_en     = sec_en_q;
  assign inc_min    = inc_min_q;
  assign inc_hour   = inc_hour_q;
  assign clr_sec    = clr_sec_q;
  assign blank_min  = blank_min_q;
  assign blank_hour = blank_hour_q;
  assign mode       = state_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenarios plus random traffic against a strobe-counting reference model.
module tb_clock_set_ctrl;
  localparam int H = 8, R = 2, B = 4;
  logic clock_in = 0, reset = 0, tick_sec = 0, tick_fast = 0, btn_mode = 0, btn_inc = 0;
  logic sec_en, inc_min, inc_hour, clr_sec, blank_min, blank_hour;
  logic [1:0] mode;
  logic [7:0] obs, exp_v;
  int errors = 0, checks = 0;
  int m_mode = 0, m_held = 0, m_bs = 0;
  bit m_pm = 1, m_pi = 1;
  clock_set_ctrl #(.HOLD_TICKS(H), .REPEAT_TICKS(R), .BLINK_TICKS(B), .CNT_W(8)) dut (
    .clock_in(clock_in), .reset(reset), .tick_sec(tick_sec), .tick_fast(tick_fast),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .sec_en(sec_en), .inc_min(inc_min),
    .inc_hour(inc_hour), .clr_sec(clr_sec), .blank_min(blank_min), .blank_hour(blank_hour),
    .mode(mode)
  );
  always #5 clock_in = ~clock_in;
  assign obs = {sec_en, inc_min, inc_hour, clr_sec, blank_min, blank_hour, mode};
  // Model: increments at press and at held-strobe counts H, H+R, H+2R...; blink phase is floor(strobes/B) parity.
  task automatic cyc(input bit r, input bit ts, input bit tf, input bit bm, input bit bi);
    bit em, ei, inc, se, clr;
    reset = r; tick_sec = ts; tick_fast = tf; btn_mode = bm; btn_inc = bi;
    em = bm && !m_pm; ei = bi && !m_pi; m_pm = bm; m_pi = bi;
    inc = 0; se = 0; clr = 0;
    if (r) begin
      m_mode = 0; m_held = 0; m_bs = 0; m_pm = 1; m_pi = 1;
    end else begin
      se = ts && m_mode == 0;
      if (em) begin
        clr = m_mode == 2; m_mode = (m_mode + 1) % 3; m_held = 0; m_bs = 0;
      end else begin
        if (m_mode == 0 || !bi) m_held = 0;
        else begin
          if (ei) inc = 1;
          if (tf) begin
            m_held++;
            if (m_held == H || (m_held > H && (m_held - H) % R == 0)) inc = 1;
          end
        end
        if (inc) m_bs = 0; else if (tf) m_bs++;
      end
    end
    exp_v = {se, inc && m_mode == 2, inc && m_mode == 1, clr,
             m_mode == 2 && (m_bs / B) % 2 == 1, m_mode == 1 && (m_bs / B) % 2 == 1, 2'(m_mode)};
    @(posedge clock_in); #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, 0);
      checks++;
      if (obs !== 8'h00) begin errors++; $display("FAIL reset i=%0d got=%b exp=%b", i, obs, 8'h00); end
    end
  endtask
  task automatic test_run_sec();
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, i % 4 == 1, 0, 0, 0);
      n += sec_en;
      checks++;
      if (obs !== exp_v || sec_en !== (i % 4 == 1)) begin errors++; $display("FAIL run_sec i=%0d got=%b exp=%b", i, obs, exp_v); end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL run_sec_count got=%0d exp=3", n); end
  endtask
  task automatic test_mode_cycle();
    int nclr = 0, nsec = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0);
      nclr += clr_sec;
      checks++;
      if (obs !== exp_v || mode !== 2'((k + 1) % 3) || clr_sec !== (k == 2)) begin
        errors++; $display("FAIL mode_press k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
        cyc(0, k < 2, 0, 0, 0);
        nclr += clr_sec; nsec += sec_en;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mode_idle k=%0d i=%0d got=%b exp=%b", k, i, obs, exp_v); end
      end
    end
    checks++;
    if (nclr != 1 || nsec != 0) begin errors++; $display("FAIL mode_counts got clr=%0d sec=%0d exp clr=1 sec=0", nclr, nsec); end
  endtask
  task automatic test_auto_repeat();
    int nh = 0, nm = 0;
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    nh += inc_hour; nm += inc_min;
    for (int s = 0; s < 14; s++)
      for (int j = 0; j < 3; j++) begin
        cyc(0, 1, j == 2, 0, 1);
        nh += inc_hour; nm += inc_min;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL repeat s=%0d got=%b exp=%b", s + 1, obs, exp_v); end
      end
    cyc(0, 0, 1, 0, 0);
    nh += inc_hour; nm += inc_min;
    checks++;
    if (nh != 5 || nm != 0) begin errors++; $display("FAIL repeat_count got hour=%0d min=%0d exp hour=5 min=0", nh, nm); end
  endtask
  task automatic test_simul();
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    checks++;
    if (mode !== 2'd2) begin errors++; $display("FAIL simul_setup got=%0d exp=2", mode); end
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (mode !== 2'd0 || clr_sec !== 1'b1 || inc_min !== 1'b0 || obs !== exp_v) begin
      errors++; $display("FAIL simul got=%b exp=%b", obs, exp_v);
    end
    cyc(0, 0, 1, 0, 0);
    checks++;
    if (obs !== exp_v || inc_min !== 1'b0) begin errors++; $display("FAIL simul_after got=%b exp=%b", obs, exp_v); end
  endtask
  task automatic test_blink();
    int tog = 0;
    logic prev;
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    prev = blank_min;
    for (int s = 0; s < 20; s++)
      for (int j = 0; j < 2; j++) begin
        cyc(0, 0, j == 0, 0, 0);
        if (s < 16 && blank_min !== prev) tog++;
        prev = blank_min;
        checks++;
        if (obs !== exp_v || blank_hour !== 1'b0) begin errors++; $display("FAIL blink s=%0d got=%b exp=%b", s + 1, obs, exp_v); end
      end
    checks++;
    if (tog != 4 || blank_min !== 1'b1) begin errors++; $display("FAIL blink_toggles got=%0d/%b exp=4/1", tog, blank_min); end
    cyc(0, 0, 0, 0, 1);
    checks++;
    if (blank_min !== 1'b0 || inc_min !== 1'b1) begin errors++; $display("FAIL blink_press got=%b exp=%b", obs, exp_v); end
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic test_reset_mid_hold();
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int s = 0; s < 10; s++) begin cyc(0, 0, 1, 0, 1); cyc(0, 0, 0, 0, 1); end
    cyc(1, 0, 1, 1, 1);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs, 8'h00); end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, i % 2 == 0, i < 8, i < 8);
      checks++;
      if (obs !== 8'h00 || obs !== exp_v) begin errors++; $display("FAIL reset_after i=%0d got=%b exp=%b", i, obs, exp_v); end
    end
  endtask
  task automatic test_random();
    bit bm = 0, bi = 0;
    int ninc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) bm = !bm;
      if ($urandom_range(7) == 0) bi = !bi;
      cyc($urandom_range(299) == 0, $urandom_range(9) == 0, $urandom_range(2) == 0, bm, bi);
      ninc += inc_hour + inc_min;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v); end
    end
    checks++;
    if (ninc == 0) begin errors++; $display("FAIL random_activity got=0 increments exp=nonzero"); end
  endtask
  initial begin
    test_reset();
    test_run_sec();
    test_mode_cycle();
    test_auto_repeat();
    test_simul();
    test_blink();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
